// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NWR_DEF   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_wsel.sv
// Write-port priority resolver: for one query address, reports whether any
// enabled write port targets it and which data wins (highest port index).
module regfile_mp_wsel
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5,
  parameter int unsigned NWR  = NWR_DEF
) (
  input  logic [AW-1:0]       qa,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  output logic                hit_c,
  output logic [XLEN-1:0]     data_c
);

  // Ascending scan so a later (higher-numbered) port overrides earlier ones.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j] && (wa[j*AW +: AW] == qa)) begin
        hit_c  = 1'b1;
        data_c = wd[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hard-wired zero register and a sequential
// clear engine. Define REGFILE_MP_BYPASS_EN to forward same-cycle write data
// to read ports; otherwise a same-cycle read returns the old contents.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NWR   = NWR_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0]  ra,
  output logic [NRD*XLEN-1:0]           rd,
  input  logic [NWR-1:0]                we,
  input  logic [NWR*$clog2(NREGS)-1:0]  wa,
  input  logic [NWR*XLEN-1:0]           wd,
  input  logic                          clr,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e          state, state_nx;
  logic [AW-1:0]   cnt, cnt_nx;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_hit  [NREGS];
  logic [XLEN-1:0] wr_data [NREGS];

  // Per-register write resolution (index 0 is resolved but never stored).
  for (genvar i = 0; i < int'(NREGS); i++) begin : g_wsel
    regfile_mp_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
      .qa     (AW'(i)),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .hit_c  (wr_hit[i]),
      .data_c (wr_data[i])
    );
  end

`ifdef REGFILE_MP_BYPASS_EN
  logic            byp_hit  [NRD];
  logic [XLEN-1:0] byp_data [NRD];

  // Same resolver keyed by each read address gives the forwarded value.
  for (genvar p = 0; p < int'(NRD); p++) begin : g_byp
    regfile_mp_wsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .qa     (ra[p*AW +: AW]),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .hit_c  (byp_hit[p]),
      .data_c (byp_data[p])
    );
  end
`endif

  // State register; reset parks the engine at the start of a clear sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= AW'(1);
      busy  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx == CLEAR);
    end
  end

  // Next-state: clr only honoured from IDLE; counter saturates at the last index.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt == LAST_IDX) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
    endcase
  end

  // Storage: clear sweep owns the array while CLEAR, write ports otherwise.
  always_ff @(posedge clk) begin
    for (int i = 1; i < int'(NREGS); i++) begin
      if (state == CLEAR) begin
        if (cnt == AW'(i)) begin
          regs[i] <= '0;
        end
      end else if (wr_hit[i]) begin
        regs[i] <= wr_data[i];
      end
    end
  end

  // Combinational read ports; x0 and any read during a clear return zero.
  always_comb begin
    rd = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      if (!busy && (ra[p*AW +: AW] != '0)) begin
        rd[p*XLEN +: XLEN] = regs[ra[p*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        if (byp_hit[p]) begin
          rd[p*XLEN +: XLEN] = byp_data[p];
        end
`endif
      end
    end
  end

endmodule
